w_fetch_agu: RTL and testbench
==============================

// Module: w_fetch_agu
// PURPOSE
//  Weight-fetch address generator and load sequencer, directly upstream of the
//  conv controller. Per weight tile: issues ROWS reads to weight SRAM, returns
//  each row to the systolic array's shadow weight registers with a row index,
//  and raises w_done once the whole tile is delivered.
//  Driven by the controller's clr_w (start tile) and w_read (fetch enable).
// PARAMETERS
//  ROWS    16  weight rows per tile (array height), >=2
//  ROW_W   128 bits per weight row (array width * weight width)
//  ADDR_W  12  weight SRAM address width
//  STRIDE  1   address increment between consecutive rows
//  RD_LAT  1   SRAM read latency in cycles, 1..4
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        synchronous, active-high reset
//  clr_w      in   1        1-cycle pulse from controller: start new tile
//  w_read     in   1        level from controller: fetch permitted this cycle
//  base_load  in   1        on clr_w, take base_addr as tile base
//  base_addr  in   ADDR_W   explicit tile base address
//  mem_en     out  1        SRAM read enable
//  mem_addr   out  ADDR_W   SRAM read address
//  mem_rdata  in   ROW_W    SRAM read data, valid RD_LAT cycles after mem_en
//  w_valid    out  1        w_data/w_row valid: array latches row this cycle
//  w_data     out  ROW_W    weight row to array
//  w_row      out  $clog2(ROWS)  destination row index, 0..ROWS-1
//  w_done     out  1        tile fully delivered; level, held until next clr_w
// BEHAVIOUR
//  Reset: mem_en=0, mem_addr=0, w_valid=0, w_data=0, w_row=0, w_done=0;
//   tile_base=0, issue_cnt=0, rcv_cnt=0, valid pipe cleared. Reset mid-tile
//   aborts it; in-flight SRAM returns are dropped.
//  States: IDLE (after reset/w_done), ISSUE (issue_cnt<ROWS),
//   DRAIN (all issued, rcv_cnt<ROWS), DONE (w_done=1).
//  clr_w: issue_cnt<=0, rcv_cnt<=0, w_done<=0, valid pipe flushed (returns from
//   the previous tile never reach w_valid); tile_base<=base_addr if base_load,
//   else tile_base<=tile_base+ROWS*STRIDE (mod 2^ADDR_W). No issue on the
//   clr_w cycle even if w_read=1. Next state ISSUE. clr_w wins over all else.
//  ISSUE: combinational mem_en = w_read & ~clr_w & (issue_cnt<ROWS);
//   mem_addr = tile_base + issue_cnt*STRIDE, truncated to ADDR_W (wraps).
//   issue_cnt++ per mem_en cycle. w_read low stalls issue; no bubbles added.
//  Return: RD_LAT-deep valid shift register tracks mem_en; when its tail is 1,
//   w_valid=1 same cycle, w_data=mem_rdata, w_row=rcv_cnt, rcv_cnt++.
//   In-flight returns complete regardless of w_read.
//  Max rate: one row/cycle. Tile latency clr_w -> w_done with w_read held
//   high = ROWS+RD_LAT+1 cycles (w_done registered: rises the cycle after the
//   last w_valid).
//  DONE: w_done=1, mem_en=0, w_valid=0, until clr_w or rst. w_read ignored.
//  w_read while IDLE after reset (no clr_w yet): no issue; w_done stays 0.
//  Outputs w_data/w_row hold last value when w_valid=0.
// TESTING
//  1 rst, base_load=1 base_addr=0x100, clr_w, w_read=1 (ROWS=16,RD_LAT=1) ->
//    addr 0x100..0x10F on 16 consecutive cycles, w_row 0..15, w_done at cycle 18.
//  2 w_read toggled 1/0 each cycle -> 16 issues over 31 cycles, addresses
//    contiguous, no dropped/duplicated w_row, w_done after last return.
//  3 second clr_w with base_load=0 -> tile_base 0x110; base 0xFF8 wraps to
//    0x000 after 0xFFF (ADDR_W=12).
//  4 clr_w at issue_cnt=7, RD_LAT=3 -> 0 further w_valid from old tile,
//    new tile restarts at w_row 0, mem_en low on clr_w cycle.
//  5 rst asserted mid-DRAIN -> all outputs 0 next cycle, w_done stays 0 until
//    a full tile after next clr_w.
//  6 DONE held 20 cycles with w_read=1 -> mem_en, w_valid stay 0; w_done=1.

Source files
------------

// File: rtl/w_fetch_agu.sv
// rtl/w_fetch_agu.sv - weight-fetch address generator and load sequencer
module w_fetch_agu #(
  parameter int ROWS   = 16,
  parameter int ROW_W  = 128,
  parameter int ADDR_W = 12,
  parameter int STRIDE = 1,
  parameter int RD_LAT = 1,
  localparam int ROW_IW = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_w,
  input  logic              w_read,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [ROW_W-1:0]  mem_rdata,
  output logic              w_valid,
  output logic [ROW_W-1:0]  w_data,
  output logic [ROW_IW-1:0] w_row,
  output logic              w_done
);

  localparam int CNT_W = $clog2(ROWS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] tile_base_q, tile_base_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  rcv_cnt_q, rcv_cnt_d;
  logic [RD_LAT-1:0] vld_pipe_q, vld_pipe_d;
  logic              w_done_q, w_done_d;
  logic [ROW_W-1:0]  w_data_q;
  logic [ROW_IW-1:0] w_row_q;
  logic              issue_left;
  logic              rtn_tail;

  // Issue and return are combinational so a row moves every cycle w_read is high.
  always_comb begin
    issue_left = (issue_cnt_q < CNT_W'(ROWS));
    mem_en     = w_read & ~clr_w & (state_q == S_ISSUE) & issue_left;
    mem_addr   = tile_base_q + ADDR_W'(32'(issue_cnt_q) * STRIDE);
    rtn_tail   = vld_pipe_q[RD_LAT-1];
    w_valid    = rtn_tail & ~clr_w;
    w_data     = w_valid ? mem_rdata : w_data_q;
    w_row      = w_valid ? ROW_IW'(rcv_cnt_q) : w_row_q;
    w_done     = w_done_q;
  end

  always_comb begin
    state_d     = state_q;
    tile_base_d = tile_base_q;
    issue_cnt_d = issue_cnt_q + CNT_W'(mem_en);
    rcv_cnt_d   = rcv_cnt_q + CNT_W'(w_valid);
    vld_pipe_d  = RD_LAT'({vld_pipe_q, mem_en});
    w_done_d    = w_done_q;

    case (state_q)
      S_ISSUE, S_DRAIN: begin
        if (rcv_cnt_d == CNT_W'(ROWS)) begin
          state_d  = S_DONE;
          w_done_d = 1'b1;
        end else if (issue_cnt_d == CNT_W'(ROWS)) begin
          state_d = S_DRAIN;
        end
      end
      default: ;
    endcase

    // A new tile discards everything still in flight from the old one.
    if (clr_w) begin
      state_d     = S_ISSUE;
      issue_cnt_d = '0;
      rcv_cnt_d   = '0;
      vld_pipe_d  = '0;
      w_done_d    = 1'b0;
      tile_base_d = base_load ? base_addr : tile_base_q + ADDR_W'(ROWS * STRIDE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tile_base_q <= '0;
      issue_cnt_q <= '0;
      rcv_cnt_q   <= '0;
      vld_pipe_q  <= '0;
      w_done_q    <= 1'b0;
      w_data_q    <= '0;
      w_row_q     <= '0;
    end else begin
      state_q     <= state_d;
      tile_base_q <= tile_base_d;
      issue_cnt_q <= issue_cnt_d;
      rcv_cnt_q   <= rcv_cnt_d;
      vld_pipe_q  <= vld_pipe_d;
      w_done_q    <= w_done_d;
      w_data_q    <= w_data;
      w_row_q     <= w_row;
    end
  end

endmodule

// File: tb/tb_w_fetch_agu.sv
// tb/tb_w_fetch_agu.sv - scoreboard bench for w_fetch_agu with SRAM model
module tb_w_fetch_agu;
  localparam int ROWS   = 16;
  localparam int ROW_W  = 128;
  localparam int ADDR_W = 12;
  localparam int STRIDE = 1;
  localparam int RD_LAT = 3;
  localparam int ROW_IW = $clog2(ROWS);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clr_w = 1'b0;
  logic              w_read = 1'b0;
  logic              base_load = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [ROW_W-1:0]  mem_rdata;
  logic              w_valid;
  logic [ROW_W-1:0]  w_data;
  logic [ROW_IW-1:0] w_row;
  logic              w_done;

  w_fetch_agu #(
    .ROWS(ROWS), .ROW_W(ROW_W), .ADDR_W(ADDR_W), .STRIDE(STRIDE), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .clr_w(clr_w), .w_read(w_read),
    .base_load(base_load), .base_addr(base_addr),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .w_valid(w_valid), .w_data(w_data), .w_row(w_row), .w_done(w_done)
  );

  always #5 clk = ~clk;

  function automatic logic [ROW_W-1:0] mem_fn(input logic [ADDR_W-1:0] a);
    logic [31:0] x;
    x = 32'(a);
    return {x * 32'h9E3779B1, ~x, (x << 7) ^ 32'h01234567, 20'hABCDE, a};
  endfunction

  // SRAM: data for the address presented with mem_en appears RD_LAT cycles later, junk otherwise
  logic [ROW_W-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= mem_en ? mem_fn(mem_addr) : {$urandom, $urandom, $urandom, $urandom};
    for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  typedef struct { logic [ADDR_W-1:0] addr; int row; } iss_t;
  typedef struct { int due; logic [ROW_W-1:0] data; int row; } ret_t;

  iss_t addr_q[$];
  ret_t ret_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int tile_issued = 0;
  int tile_delivered = 0;
  bit exp_done = 1'b0;
  logic [ROW_W-1:0] last_data = '0;
  int last_row = 0;
  logic [ADDR_W-1:0] model_base = '0;
  bit mon_exp_en, mon_set_done;
  iss_t mon_e;
  ret_t mon_r;

  task automatic check(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares every cycle against the expected issue/return queues
  always @(negedge clk) begin
    mon_set_done = 1'b0;
    if (!rst) begin
      if (clr_w) begin
        check("mem_en_on_clr", mem_en, 0);
        check("w_valid_on_clr", w_valid, 0);
        check("w_data_hold_clr", w_data, last_data);
        check("w_row_hold_clr", w_row, last_row);
      end else begin
        mon_exp_en = w_read && (addr_q.size() > 0);
        check("mem_en", mem_en, mon_exp_en);
        if (mem_en && addr_q.size() > 0) begin
          mon_e = addr_q.pop_front();
          check("mem_addr", mem_addr, mon_e.addr);
          ret_q.push_back('{due: cyc + RD_LAT, data: mem_fn(mon_e.addr), row: mon_e.row});
          tile_issued++;
        end
        if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
          mon_r = ret_q.pop_front();
          check("w_valid", w_valid, 1);
          check("w_data", w_data, mon_r.data);
          check("w_row", w_row, mon_r.row);
          last_data = mon_r.data;
          last_row  = mon_r.row;
          tile_delivered++;
          if (tile_delivered == ROWS) mon_set_done = 1'b1;
        end else begin
          check("w_valid_idle", w_valid, 0);
          check("w_data_hold", w_data, last_data);
          check("w_row_hold", w_row, last_row);
        end
      end
      check("w_done", w_done, exp_done);
    end
    if (rst) begin
      exp_done = 1'b0; tile_issued = 0; tile_delivered = 0; last_data = '0; last_row = 0;
    end else if (clr_w) begin
      exp_done = 1'b0; tile_issued = 0; tile_delivered = 0;
    end else if (mon_set_done) begin
      exp_done = 1'b1;
    end
    cyc++;
  end

  task automatic start_tile(input bit load, input logic [ADDR_W-1:0] addr, input bit rd);
    @(posedge clk); #1;
    model_base = load ? addr : model_base + ADDR_W'(ROWS * STRIDE);
    addr_q.delete();
    ret_q.delete();
    for (int r = 0; r < ROWS; r++)
      addr_q.push_back('{addr: ADDR_W'(32'(model_base) + r * STRIDE), row: r});
    clr_w = 1'b1; base_load = load; base_addr = addr; w_read = rd;
    @(posedge clk); #1;
    clr_w = 1'b0; base_load = 1'($urandom); base_addr = ADDR_W'($urandom);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; clr_w = 1'b0;
    addr_q.delete();
    ret_q.delete();
    model_base = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_done(input int limit, input bit toggle, output int n);
    n = 0;
    while (n < limit) begin
      @(negedge clk);
      n++;
      if (w_done) break;
      @(posedge clk); #1;
      if (toggle) w_read = ~w_read;
    end
    if (!w_done) begin
      vectors++; miscompares++;
      $display("FAIL wait_done: w_done not seen within %0d cycles", limit);
    end
  endtask

  task automatic wait_issued(input int target, input bit need_drain);
    int k;
    k = 0;
    while (k < 200) begin
      @(negedge clk);
      k++;
      if (tile_issued >= target && (!need_drain || tile_delivered < ROWS)) break;
    end
    if (k >= 200) begin
      vectors++; miscompares++;
      $display("FAIL wait_issued: %0d issues not seen", target);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit ab;
    int ab_at;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_w_valid", w_valid, 0);
    check("rst_w_data", w_data, 0);
    check("rst_w_row", w_row, 0);
    check("rst_w_done", w_done, 0);
    @(posedge clk); #1 w_read = 1'b1;
    repeat (5) @(posedge clk);

    // explicit base, full rate
    start_tile(1'b1, 12'h100, 1'b1);
    wait_done(200, 1'b0, n);
    check("tile_latency", n, ROWS + RD_LAT + 1);

    // DONE held with w_read high
    repeat (20) begin
      @(negedge clk);
      check("done_held", w_done, 1);
    end

    // base increments to 0x110; w_read alternates
    start_tile(1'b0, 12'h000, 1'b1);
    wait_done(200, 1'b1, n);
    check("toggle_latency", n, 2 * ROWS - 1 + RD_LAT + 1);
    @(posedge clk); #1 w_read = 1'b1;

    // address wrap
    start_tile(1'b1, 12'hFF8, 1'b1);
    wait_done(200, 1'b0, n);
    check("wrap_latency", n, ROWS + RD_LAT + 1);

    // restart mid-issue
    start_tile(1'b1, 12'h200, 1'b1);
    wait_issued(7, 1'b0);
    start_tile(1'b1, 12'h300, 1'b1);
    wait_done(200, 1'b0, n);
    check("restart_latency", n, ROWS + RD_LAT + 1);

    // reset mid-drain
    start_tile(1'b0, 12'h000, 1'b1);
    wait_issued(ROWS, 1'b1);
    do_reset();
    @(negedge clk);
    check("mid_rst_mem_en", mem_en, 0);
    check("mid_rst_mem_addr", mem_addr, 0);
    check("mid_rst_w_valid", w_valid, 0);
    check("mid_rst_w_data", w_data, 0);
    check("mid_rst_w_row", w_row, 0);
    check("mid_rst_w_done", w_done, 0);
    repeat (10) begin
      @(negedge clk);
      check("idle_no_done", w_done, 0);
    end
    start_tile(1'b0, 12'h000, 1'b1);
    wait_done(200, 1'b0, n);

    // randomized tiles with stalls and occasional aborts
    for (int t = 0; t < 15; t++) begin
      start_tile(1'($urandom_range(0, 1)), ADDR_W'($urandom), 1'($urandom_range(0, 1)));
      ab = ($urandom_range(0, 3) == 0);
      ab_at = $urandom_range(1, 30);
      n = 0;
      while (n < 400) begin
        @(negedge clk);
        n++;
        if (w_done) break;
        if (ab && n == ab_at) break;
        @(posedge clk); #1;
        w_read = ($urandom_range(0, 3) != 0);
      end
      if (!w_done && !(ab && n == ab_at)) begin
        vectors++; miscompares++;
        $display("FAIL random_tile %0d: no w_done within 400 cycles", t);
      end
      if (t == 9) do_reset();
    end
    repeat (10) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
